// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared decode constants, state enum and phase encodings for the sequencer
package simple_pkg;

  typedef enum logic [1:0] {
    CLS_LD    = 2'b00,
    CLS_ST    = 2'b01,
    CLS_BR    = 2'b10,
    CLS_ARITH = 2'b11
  } cls_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_CMP = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SLR = 4'd9;
  localparam logic [3:0] OP_SRL = 4'd10;
  localparam logic [3:0] OP_SRA = 4'd11;
  localparam logic [3:0] OP_IN  = 4'd12;
  localparam logic [3:0] OP_OUT = 4'd13;
  localparam logic [3:0] OP_HLT = 4'd15;

  // instr[13:11] sub-class inside the 10 class
  localparam logic [2:0] SUB_LI  = 3'b000;
  localparam logic [2:0] SUB_B   = 3'b100;
  localparam logic [2:0] SUB_BCC = 3'b111;

  localparam logic [2:0] COND_BE  = 3'd0;
  localparam logic [2:0] COND_BLT = 3'd1;
  localparam logic [2:0] COND_BLE = 3'd2;
  localparam logic [2:0] COND_BNE = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_P5,
    ST_HALT
  } state_e;

  localparam logic [4:0] PH_NONE = 5'b00000;
  localparam logic [4:0] PH_P1   = 5'b00001;
  localparam logic [4:0] PH_P2   = 5'b00010;
  localparam logic [4:0] PH_P3   = 5'b00100;
  localparam logic [4:0] PH_P4   = 5'b01000;
  localparam logic [4:0] PH_P5   = 5'b10000;

  function automatic logic op_sets_flags(input logic [3:0] op);
    return (op <= OP_MOV) || (op >= OP_SLL && op <= OP_SRA);
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op <= OP_XOR) || (op == OP_MOV) || (op >= OP_SLL && op <= OP_IN);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational condition-code evaluation against {S,Z,C,V}
module branch_cond_eval
  import simple_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic s, z, v, unused_c;

  assign s        = flags[3];
  assign z        = flags[2];
  assign unused_c = flags[1];
  assign v        = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_BE:  taken = z;
      COND_BLT: taken = s ^ v;
      COND_BLE: taken = z | (s ^ v);
      COND_BNE: taken = ~z;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/phase_controller.sv
// rtl/phase_controller.sv - five-phase instruction sequencer: decode, strobes, flags, branch, run/stop/halt
module phase_controller
  import simple_pkg::*;
#(
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec_btn,
  input  logic [15:0] instr,
  input  logic        alu_s,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic [4:0]  phase,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        operand_we,
  output logic [3:0]  alu_op,
  output logic [3:0]  alu_d,
  output logic        dr_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        led_we,
  output logic        reg_we,
  output logic [3:0]  flags_q,
  output logic        branch_taken,
  output logic        running,
  output logic        halted
);

  state_e     state_q, state_d;
  logic       running_q, running_d;
  logic       stop_q, stop_d;
  logic       taken_q, taken_d;
  logic       boot_q;
  logic [3:0] flags_d;

  cls_e       cls;
  logic [3:0] op3;
  logic       is_arith, is_ld, is_st, is_li, is_b, is_bcc, is_hlt, is_out;
  logic       flag_we, writes_reg, cond_taken;

  assign cls      = cls_e'(instr[15:14]);
  assign op3      = instr[7:4];
  assign is_arith = (cls == CLS_ARITH);
  assign is_ld    = (cls == CLS_LD);
  assign is_st    = (cls == CLS_ST);
  assign is_li    = (cls == CLS_BR) && (instr[13:11] == SUB_LI);
  assign is_b     = (cls == CLS_BR) && (instr[13:11] == SUB_B);
  assign is_bcc   = (cls == CLS_BR) && (instr[13:11] == SUB_BCC);
  assign is_hlt   = is_arith && (op3 == OP_HLT);
  assign is_out   = is_arith && (op3 == OP_OUT);
  assign flag_we  = is_arith && op_sets_flags(op3);
  assign writes_reg = (is_arith && op_writes_reg(op3)) || is_ld || is_li;

  assign alu_op = is_arith ? op3 : OP_ADD;
  assign alu_d  = instr[3:0];

  // Conditions are judged against the flags left by earlier instructions
  branch_cond_eval u_cond (
    .cond  (instr[10:8]),
    .flags (flags_q),
    .taken (cond_taken)
  );

  assign running      = running_q;
  assign halted       = (state_q == ST_HALT);
  assign branch_taken = taken_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      stop_q    <= 1'b0;
      taken_q   <= 1'b0;
      flags_q   <= 4'b0000;
      boot_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      stop_q    <= stop_d;
      taken_q   <= taken_d;
      flags_q   <= flags_d;
      boot_q    <= 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    running_d  = running_q;
    stop_d     = stop_q;
    taken_d    = taken_q;
    flags_d    = flags_q;
    phase      = PH_NONE;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    operand_we = 1'b0;
    dr_we      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    led_we     = 1'b0;
    reg_we     = 1'b0;

    if (exec_btn && state_q != ST_IDLE && state_q != ST_HALT)
      stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (exec_btn || (RUN_ON_RESET && boot_q)) begin
          state_d   = ST_P1;
          running_d = 1'b1;
        end
      end
      ST_P1: begin
        phase   = PH_P1;
        ir_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_P2;
      end
      ST_P2: begin
        phase      = PH_P2;
        operand_we = 1'b1;
        state_d    = ST_P3;
      end
      ST_P3: begin
        phase   = PH_P3;
        dr_we   = 1'b1;
        taken_d = is_b || (is_bcc && cond_taken);
        if (flag_we)
          flags_d = {alu_s, alu_z, alu_c, alu_v};
        if (is_hlt) begin
          state_d   = ST_HALT;
          running_d = 1'b0;
          stop_d    = 1'b0;
        end else begin
          state_d = ST_P4;
        end
      end
      ST_P4: begin
        phase   = PH_P4;
        mem_re  = is_ld;
        mem_we  = is_st;
        led_we  = is_out;
        pc_we   = taken_q;
        pc_sel  = taken_q;
        state_d = ST_P5;
      end
      ST_P5: begin
        phase   = PH_P5;
        reg_we  = writes_reg;
        taken_d = 1'b0;
        if (running_q && !stop_q && !exec_btn) begin
          state_d = ST_P1;
        end else begin
          state_d   = ST_IDLE;
          running_d = 1'b0;
          stop_d    = 1'b0;
        end
      end
      ST_HALT: stop_d = 1'b0;
      default: state_d = ST_IDLE;
    endcase

    // Reset overrides whatever phase the registered state still shows
    if (rst) begin
      phase      = PH_NONE;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      operand_we = 1'b0;
      dr_we      = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      led_we     = 1'b0;
      reg_we     = 1'b0;
    end
  end

endmodule

// File: doc/phase_controller.md
Name: phase_controller

Overview:
- Multi-cycle sequencer for the 16-bit processor. Steps each instruction through five phases (fetch, decode/operand read, execute, memory, writeback).
- Decodes the instruction register, drives the ALU opcode and shift amount, and owns the SZCV flag register.
- Evaluates conditional branches, emits write strobes for PC, IR, register file, memory and LED latch, and handles run/stop and halt.
- Sits between instruction register and datapath; the ALU is purely combinational and is sequenced by this block.

Parameters:
- RUN_ON_RESET, 0, 1 = leave IDLE and start fetching on the first cycle after reset without waiting for exec_btn.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- exec_btn  input  1  single-cycle start/stop pulse (already debounced)
- instr  input  16  current IR contents
- alu_s, alu_z, alu_c, alu_v  input  1 each  ALU flag outputs
- phase  output  5  one-hot P1..P5 (bit0=P1); 0 in IDLE/HALT
- ir_we  output  1  load IR from memory
- pc_we  output  1  PC write strobe
- pc_sel  output  1  0 = PC+1, 1 = branch target
- operand_we  output  1  latch register-file read ports into AR/BR
- alu_op  output  4  opcode to ALU
- alu_d  output  4  shift amount / immediate nibble
- dr_we  output  1  latch ALU result
- mem_re, mem_we  output  1 each  data-memory read/write
- led_we  output  1  latch LED/7-seg output
- reg_we  output  1  register-file write
- flags_q  output  4  {S,Z,C,V} flag register
- branch_taken  output  1  registered condition result for current instruction
- running, halted  output  1 each  status

Behaviour:
- Reset:
  - State becomes IDLE; all strobes, phase, flags_q, branch_taken, running and halted are 0.
  - rst wins over every other event, including mid-instruction; no strobe fires in the reset cycle.
- States: IDLE, P1, P2, P3, P4, P5, HALT. Fixed latency of 5 cycles per instruction.
- IDLE:
  - exec_btn goes to P1 and sets running=1.
  - With RUN_ON_RESET=1, IDLE goes to P1 unconditionally on the first post-reset cycle.
- Decode classes:
  - instr[15:14]=11: arithmetic; op3=instr[7:4], d=instr[3:0].
  - 00: LD. 01: ST.
  - 10 with instr[13:11]=000: LI.
  - 10 with instr[13:11]=100: B (unconditional).
  - 10 with instr[13:11]=111: Bcc, cond=instr[10:8]. BE: Z. BLT: S^V. BLE: Z|(S^V). BNE: !Z. Other cond codes are not taken.
  - Any other encoding is a NOP.
- Arithmetic op3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP, 6 MOV, 8 SLL, 9 SLR, 10 SRL, 11 SRA, 12 IN, 13 OUT, 15 HLT. op3 7 and 14 are NOPs.
- alu_op: op3 for arithmetic, 0 (ADD) for LD/ST/branch address generation. alu_d = instr[3:0] always.
- P1: ir_we=1, pc_we=1, pc_sel=0.
- P2: operand_we=1.
- P3:
  - dr_we=1.
  - flag_we (internal) for op3 in {0-6, 8-11}; flags_q <= {alu_s, alu_z, alu_c, alu_v} at end of P3.
  - Bcc evaluates cond against flags_q as held before this P3 and registers branch_taken. B sets branch_taken=1.
  - HLT: P3 goes to HALT, halted=1, running=0, no further strobes.
- P4:
  - mem_re for LD, mem_we for ST, led_we for OUT (op3=13).
  - pc_we=1 and pc_sel=1 iff branch_taken.
- P5:
  - reg_we for op3 in {0-4, 6, 8-12}, LD, and LI. CMP, OUT and NOPs write nothing.
  - branch_taken clears.
- Next after P5: P1 if running and no stop pending, else IDLE with running=0.
- Stop:
  - exec_btn while running (any of P1..P5) sets stop_pending.
  - The current instruction completes through P5, then the block goes to IDLE. stop_pending clears on entering IDLE.
- HALT: exec_btn is ignored; only rst exits.
- Simultaneous events:
  - exec_btn in the P3 cycle of HLT: HALT wins, stop_pending is discarded.
  - exec_btn in the P5 cycle: treated as a stop request for this instruction.
- All strobes are combinational from registered state and the registered decode; never more than one phase bit is set.

Decomposition:
- Package simple_pkg holds:
  - class codes (ARITH, LD, ST, BR) and op3 constants (ADD..HLT);
  - cond codes (BE, BLT, BLE, BNE);
  - phase state enum and the one-hot phase constants.
- One natural sub-module: branch_cond_eval, combinational (cond[2:0], flags[3:0] -> taken).

Test Plan:
- Reset, exec_btn, instr=0xC100 (ADD, rd=1, rs=0) -> phase 00001, 00010, 00100, 01000, 10000 on consecutive cycles; flag_we update in P3; reg_we only in P5; phase=00001 again on cycle 6.
- instr=0xC0F0 (HLT) -> halted=1 and phase=0 the cycle after P3; reg_we never asserted; exec_btn pulse leaves HALT unchanged; rst clears halted.
- CMP of equal operands (alu_z=1, instr=0xC050), then instr=0xB805 (BE) -> branch_taken=1, pc_we=1 and pc_sel=1 in P4. Repeat with alu_z=0 -> no pc_we in P4.
- exec_btn pulse during P3 of an ADD -> P4 and P5 still complete with reg_we=1, then phase=0 and running=0.
- rst asserted during P4 of ST (instr=0x4000) -> mem_we=0 in that cycle; next cycle phase=0, flags_q=0000, running=0.
- instr=0xC0D0 (OUT) -> led_we=1 in P4 only; flags_q unchanged; reg_we=0 in P5.
